// File: rtl/dbus_pt_responder_pkg.sv
// Shared data-bus types and helpers used by the MMU, the LSU and bus responders.
package common;

   // Transfer size of a data-bus access
   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   // Request issued by an initiator; strobe and data are already lane-aligned
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   // Response returned by a responder
   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   // Natural-alignment test for an access of the given size
   function automatic logic DBUS_ALIGN_OK(input msize_t size, input logic [63:0] addr);
      logic ok;
      case (size)
         MSIZE1:  ok = 1'b1;
         MSIZE2:  ok = (addr[0] == 1'b0);
         MSIZE4:  ok = (addr[1:0] == 2'b00);
         MSIZE8:  ok = (addr[2:0] == 3'b000);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dbus_pt_responder_ram.sv
// Word memory behind the responder: byte-strobed bus write port, full-word
// backdoor write port and a registered read port that yields the pre-write word.
module dbus_resp_ram #(
   parameter  int DEPTH_WORDS = 512,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [7:0]       wr_strobe,
   input  logic [63:0]      wr_data,
   input  logic             bd_we,
   input  logic [IDX_W-1:0] bd_idx,
   input  logic [63:0]      bd_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [63:0]      rd_data
);

   logic [63:0] mem_r [DEPTH_WORDS];

   // Memory update: backdoor first, strobed bus bytes afterwards so they win on a shared word
   always_ff @(posedge clk) begin
      if (bd_we) begin
         mem_r[bd_idx] <= bd_data;
      end
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (wr_strobe[i]) begin
               mem_r[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Read register: holds the addressed word only for the cycle after a read, zero otherwise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= 64'd0;
      end else if (rd_en) begin
         rd_data <= mem_r[rd_idx];
      end else begin
         rd_data <= 64'd0;
      end
   end

endmodule

// File: rtl/dbus_pt_responder.sv
// Fixed-latency data-bus responder backed by a 64-bit word memory, with a
// backdoor write port for preloading page tables.
module dbus_pt_responder
   import common::*;
#(
   parameter int          DEPTH_WORDS = 512,
   parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
   parameter int          LATENCY     = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  dbus_req_t                      dreq,
   output dbus_resp_t                     dresp,
   output logic                           err,
   input  logic                           bd_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] bd_idx,
   input  logic [63:0]                    bd_data
);

   localparam int          IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) * 64'd8;
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [63:0] addr_r;
   msize_t      size_r;
   logic [7:0]  strobe_r;
   logic [63:0] data_r;
   logic        addr_ok_r;
   logic        data_ok_r;
   logic        err_r;

   logic [63:0]      off_s;
   logic             in_range_s;
   logic             aligned_s;
   logic             good_s;
   logic             commit_s;
   logic [IDX_W-1:0] idx_s;
   logic             wr_en_s;
   logic             rd_en_s;
   logic [63:0]      rd_data_s;

   // Decode the latched request; commit_s marks the edge that enters RESP
   always_comb begin
      off_s      = addr_r - BASE_ADDR;
      in_range_s = (addr_r >= BASE_ADDR) && (off_s < SPAN);
      aligned_s  = DBUS_ALIGN_OK(size_r, addr_r);
      good_s     = in_range_s && aligned_s;
      idx_s      = off_s[IDX_W+2:3];
      commit_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
      rd_en_s    = commit_s && good_s;
      wr_en_s    = commit_s && good_s && (strobe_r != 8'd0);
   end

   // Transaction FSM: latch in IDLE, count down in WAIT, one-cycle response in RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         addr_r    <= 64'd0;
         size_r    <= MSIZE1;
         strobe_r  <= 8'd0;
         data_r    <= 64'd0;
         addr_ok_r <= 1'b0;
         data_ok_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         addr_ok_r <= 1'b0;
         data_ok_r <= 1'b0;
         err_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (dreq.valid) begin
                  addr_r   <= dreq.addr;
                  size_r   <= dreq.size;
                  strobe_r <= dreq.strobe;
                  data_r   <= dreq.data;
                  cnt_r    <= CNT_LOAD;
                  state_r  <= ST_WAIT;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt_r == 4'd0) begin
                  addr_ok_r <= 1'b1;
                  data_ok_r <= 1'b1;
                  err_r     <= !good_s;
                  state_r   <= ST_RESP;
               end else begin
                  cnt_r     <= cnt_r - 4'd1;
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 4'd0;
            end
         endcase
      end
   end

   dbus_resp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en_s),
      .wr_idx    (idx_s),
      .wr_strobe (strobe_r),
      .wr_data   (data_r),
      .bd_we     (bd_we),
      .bd_idx    (bd_idx),
      .bd_data   (bd_data),
      .rd_en     (rd_en_s),
      .rd_idx    (idx_s),
      .rd_data   (rd_data_s)
   );

   assign dresp = '{addr_ok: addr_ok_r, data_ok: data_ok_r, data: rd_data_s};
   assign err   = err_r;

endmodule

// File: tb/tb_dbus_pt_responder.sv
// Directed bench for dbus_pt_responder with hand-computed expectations.
module tb_dbus_pt_responder;
   import common::*;

   localparam int LAT = 2;

   logic       clk;
   logic       reset;
   dbus_req_t  dreq;
   dbus_resp_t dresp;
   logic       err;
   logic       bd_we;
   logic [8:0] bd_idx;
   logic [63:0] bd_data;

   int checks;
   int errors;

   dbus_pt_responder #(
      .DEPTH_WORDS (512),
      .BASE_ADDR   (64'h8000_0000),
      .LATENCY     (LAT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .dreq    (dreq),
      .dresp   (dresp),
      .err     (err),
      .bd_we   (bd_we),
      .bd_idx  (bd_idx),
      .bd_data (bd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bd_write(input int idx, input logic [63:0] d);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_idx  = 9'(idx);
      bd_data = d;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   task automatic drive_req(input logic [63:0] a, input msize_t sz, input logic [7:0] st, input logic [63:0] d);
      dreq.valid  = 1'b1;
      dreq.addr   = a;
      dreq.size   = sz;
      dreq.strobe = st;
      dreq.data   = d;
   endtask

   // One complete transaction; hold keeps valid high until data_ok is seen
   task automatic do_txn(input string tag, input logic [63:0] a, input msize_t sz,
                         input logic [7:0] st, input logic [63:0] d, input bit hold,
                         input logic [63:0] exp_data, input logic exp_err);
      int          lat;
      logic [63:0] got_d;
      logic        got_e;
      logic        got_a;
      lat   = 0;
      got_d = 64'd0;
      got_e = 1'b0;
      got_a = 1'b0;
      @(negedge clk);
      drive_req(a, sz, st, d);
      @(posedge clk);
      #1;
      if (!hold) dreq.valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (dresp.data_ok) begin
            lat   = i;
            got_d = dresp.data;
            got_e = err;
            got_a = dresp.addr_ok;
            break;
         end
      end
      check_eq({tag, ".lat"}, 64'(lat), 64'(LAT));
      check_eq({tag, ".addr_ok"}, {63'd0, got_a}, 64'd1);
      check_eq({tag, ".data"}, got_d, exp_data);
      check_eq({tag, ".err"}, {63'd0, got_e}, {63'd0, exp_err});
      @(posedge clk);
      #1;
      dreq.valid = 1'b0;
      check_eq({tag, ".b2b"}, {62'd0, dresp.addr_ok, dresp.data_ok}, 64'd0);
   endtask

   initial begin
      logic seen;
      checks  = 0;
      errors  = 0;
      dreq    = '0;
      bd_we   = 1'b0;
      bd_idx  = 9'd0;
      bd_data = 64'd0;
      reset   = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst.addr_ok", {63'd0, dresp.addr_ok}, 64'd0);
      check_eq("rst.data_ok", {63'd0, dresp.data_ok}, 64'd0);
      check_eq("rst.data", dresp.data, 64'd0);
      check_eq("rst.err", {63'd0, err}, 64'd0);
      reset = 1'b1;

      // Basic read and strobed write with pre-write response data
      bd_write(0, 64'h0000_0000_2000_0401);
      bd_write(2, 64'h1111_2222_3333_4444);
      do_txn("rd0", 64'h8000_0000, MSIZE8, 8'h00, 64'd0, 1'b0, 64'h0000_0000_2000_0401, 1'b0);
      do_txn("wr2", 64'h8000_0010, MSIZE8, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 64'h1111_2222_3333_4444, 1'b0);
      do_txn("rd2", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1'b0, 64'h1111_2222_CCCC_DDDD, 1'b0);

      // Range and alignment boundaries
      bd_write(511, 64'hCAFE_F00D_1234_5678);
      do_txn("rdlast", 64'h8000_0FF8, MSIZE8, 8'h00, 64'd0, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0);
      do_txn("oor_hi", 64'h8000_1000, MSIZE8, 8'h00, 64'd0, 1'b0, 64'd0, 1'b1);
      do_txn("oor_lo", 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, 1'b0, 64'd0, 1'b1);
      do_txn("mis4", 64'h8000_0002, MSIZE4, 8'h00, 64'd0, 1'b0, 64'd0, 1'b1);
      do_txn("ok2", 64'h8000_0002, MSIZE2, 8'h00, 64'd0, 1'b0, 64'h0000_0000_2000_0401, 1'b0);
      do_txn("ok1", 64'h8000_0003, MSIZE1, 8'h00, 64'd0, 1'b0, 64'h0000_0000_2000_0401, 1'b0);
      do_txn("badwr", 64'h8000_0004, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b1);
      do_txn("rd0b", 64'h8000_0000, MSIZE8, 8'h00, 64'd0, 1'b0, 64'h0000_0000_2000_0401, 1'b0);

      // Three-level walk with valid held until data_ok
      bd_write(1, 64'h0000_0000_2000_0801);
      do_txn("walk1", 64'h8000_0000, MSIZE8, 8'h00, 64'd0, 1'b1, 64'h0000_0000_2000_0401, 1'b0);
      do_txn("walk2", 64'h8000_0008, MSIZE8, 8'h00, 64'd0, 1'b1, 64'h0000_0000_2000_0801, 1'b0);
      do_txn("walk3", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 1'b1, 64'h1111_2222_CCCC_DDDD, 1'b0);

      // Valid dropped during WAIT of a full write
      bd_write(3, 64'h5A5A_5A5A_5A5A_5A5A);
      do_txn("wr3", 64'h8000_0018, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0);
      do_txn("rd3", 64'h8000_0018, MSIZE8, 8'h00, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);

      // Reset during WAIT of a write: aborted, memory unchanged
      bd_write(4, 64'hDEAD_BEEF_0000_1111);
      @(negedge clk);
      drive_req(64'h8000_0020, MSIZE8, 8'hFF, 64'd0);
      @(posedge clk);
      #1;
      dreq.valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("rstw.outs", {dresp.addr_ok, dresp.data_ok, err, dresp.data[60:0]}, 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         seen = seen | dresp.data_ok;
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         seen = seen | dresp.data_ok;
      end
      check_eq("rstw.noresp", {63'd0, seen}, 64'd0);
      do_txn("rd4", 64'h8000_0020, MSIZE8, 8'h00, 64'd0, 1'b0, 64'hDEAD_BEEF_0000_1111, 1'b0);

      // Backdoor and bus write to the same word on the same edge
      bd_write(5, 64'd0);
      @(negedge clk);
      drive_req(64'h8000_0028, MSIZE8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
      @(posedge clk);
      @(negedge clk);
      dreq.valid = 1'b0;
      @(negedge clk);
      bd_we   = 1'b1;
      bd_idx  = 9'd5;
      bd_data = 64'h5555_5555_6666_6666;
      @(posedge clk);
      #1;
      check_eq("coll.data_ok", {63'd0, dresp.data_ok}, 64'd1);
      check_eq("coll.data", dresp.data, 64'd0);
      @(negedge clk);
      bd_we = 1'b0;
      do_txn("rd5", 64'h8000_0028, MSIZE8, 8'h00, 64'd0, 1'b0, 64'h5555_5555_BBBB_BBBB, 1'b0);

      // Reset during RESP clears outputs asynchronously
      @(negedge clk);
      drive_req(64'h8000_0000, MSIZE8, 8'h00, 64'd0);
      @(posedge clk);
      #1;
      dreq.valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_eq("rstr.pre", dresp.data, 64'h0000_0000_2000_0401);
      reset = 1'b0;
      #1;
      check_eq("rstr.ok", {62'd0, dresp.addr_ok, dresp.data_ok}, 64'd0);
      check_eq("rstr.data", dresp.data, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      do_txn("post", 64'h8000_0008, MSIZE8, 8'h00, 64'd0, 1'b0, 64'h0000_0000_2000_0801, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
